bdf_ctrl_seq: RTL and testbench

BDF_CTRL_SEQ -- requirements
Module: bdf_ctrl_seq

---
 rtl/defines_pkg.sv | 18 +
 rtl/bdf_prog_mem.sv | 35 +++
 rtl/bdf_ctrl_seq.sv | 149 ++++++++++++++
 tb/tb_bdf_ctrl_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/defines_pkg.sv
// Shared constants and state encoding for the BDF control sequencer.
package defines_pkg;

    localparam int CODE_WIDTH  = 8;
    localparam int CODE_LENGTH = 16;
    localparam int RUN_CYCLES  = 1000;
    localparam int STOP_CYCLES = 1000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GAP,
        RUN,
        STOP,
        DONE
    } bdf_seq_state_t;

endpackage

// File: rtl/bdf_prog_mem.sv
// Program store: register file with one write port and one registered read port.
module bdf_prog_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    // Write-first: a word written on the same edge it is read is returned directly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= (wr_en_i && (wr_addr_i == rd_addr_i)) ? wr_data_i : mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/bdf_ctrl_seq.sv
// Streams a stored control program into the dataflow core, then runs and stops it.
module bdf_ctrl_seq
    import defines_pkg::*;
#(
    parameter int CTRL_WIDTH  = defines_pkg::CODE_WIDTH,
    parameter int PROG_DEPTH  = defines_pkg::CODE_LENGTH,
    parameter int RUN_CYCLES  = defines_pkg::RUN_CYCLES,
    parameter int STOP_CYCLES = defines_pkg::STOP_CYCLES
) (
    input  logic                          clk2,
    input  logic                          rst2,
    input  logic                          prog_wr_en,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_wr_addr,
    input  logic [CTRL_WIDTH-1:0]         prog_wr_data,
    input  logic [$clog2(PROG_DEPTH):0]   prog_len,
    input  logic                          go,
    input  logic                          abort,
    output logic [CTRL_WIDTH-1:0]         ctrl_out,
    output logic                          load_ctrl,
    output logic                          start_ctrl,
    output logic                          stop_ctrl,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int AW      = $clog2(PROG_DEPTH);
    localparam int LW      = AW + 1;
    localparam int CNT_MAX = (RUN_CYCLES > STOP_CYCLES) ? RUN_CYCLES : STOP_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(PROG_DEPTH);

    bdf_seq_state_t  state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_d;
    logic            idle_like, len_ok;
    logic            mem_wr_en, mem_rd_en;
    logic [AW-1:0]   mem_rd_addr;
    logic            load_q, start_q, stop_q, busy_q, done_q, err_q;

    assign idle_like   = (state_q == IDLE) || (state_q == DONE);
    assign len_ok      = (prog_len != '0) && (prog_len <= DEPTH_L);
    assign mem_wr_en   = prog_wr_en && idle_like;
    assign mem_rd_addr = (state_q == LOAD) ? idx_q[AW-1:0] : '0;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        mem_rd_en = 1'b0;
        err_d     = prog_wr_en && !idle_like;
        case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    if (len_ok) begin
                        // Word 0 is fetched now so it is on ctrl_out in the first LOAD cycle.
                        state_d   = LOAD;
                        len_d     = prog_len;
                        idx_d     = LW'(1);
                        mem_rd_en = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = STOP;
                    cnt_d   = CW'(STOP_CYCLES - 1);
                end else if (idx_q < len_q) begin
                    mem_rd_en = 1'b1;
                    idx_d     = idx_q + LW'(1);
                end else begin
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = abort ? STOP : RUN;
                cnt_d   = abort ? CW'(STOP_CYCLES - 1) : CW'(RUN_CYCLES - 1);
            end
            RUN: begin
                if (abort || (cnt_q == '0)) begin
                    state_d = STOP;
                    cnt_d   = CW'(STOP_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Status/control flags are registered decodes of the next state.
    always_ff @(posedge clk2 or negedge rst2) begin
        if (!rst2) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            load_q  <= (state_d == LOAD);
            start_q <= (state_d == RUN);
            stop_q  <= (state_d == STOP);
            busy_q  <= (state_d == LOAD) || (state_d == GAP) || (state_d == RUN) || (state_d == STOP);
            done_q  <= (state_d == DONE);
            err_q   <= err_d;
        end
    end

    bdf_prog_mem #(
        .DATA_W (CTRL_WIDTH),
        .DEPTH  (PROG_DEPTH),
        .ADDR_W (AW)
    ) u_mem (
        .clk_i     (clk2),
        .rst_ni    (rst2),
        .wr_en_i   (mem_wr_en),
        .wr_addr_i (prog_wr_addr),
        .wr_data_i (prog_wr_data),
        .rd_en_i   (mem_rd_en),
        .rd_addr_i (mem_rd_addr),
        .rd_data_o (ctrl_out)
    );

    assign load_ctrl  = load_q;
    assign start_ctrl = start_q;
    assign stop_ctrl  = stop_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_bdf_ctrl_seq.sv
// Directed bench for bdf_ctrl_seq with a timeline model checked every cycle.
module tb_bdf_ctrl_seq;

    localparam int DEPTH = 16;
    localparam int RUNC  = 1000;
    localparam int STOPC = 1000;
    localparam int P_IDLE = 0, P_LOAD = 1, P_GAP = 2, P_RUN = 3, P_STOP = 4, P_DONE = 5;

    logic       clk2 = 1'b0;
    logic       rst2 = 1'b0;
    logic       prog_wr_en = 1'b0;
    logic [3:0] prog_wr_addr = '0;
    logic [7:0] prog_wr_data = '0;
    logic [4:0] prog_len = '0;
    logic       go = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] ctrl_out;
    logic       load_ctrl, start_ctrl, stop_ctrl, busy, done, err;

    always #5 clk2 = ~clk2;

    bdf_ctrl_seq #(
        .CTRL_WIDTH (8),
        .PROG_DEPTH (DEPTH),
        .RUN_CYCLES (RUNC),
        .STOP_CYCLES(STOPC)
    ) dut (
        .clk2        (clk2),
        .rst2        (rst2),
        .prog_wr_en  (prog_wr_en),
        .prog_wr_addr(prog_wr_addr),
        .prog_wr_data(prog_wr_data),
        .prog_len    (prog_len),
        .go          (go),
        .abort       (abort),
        .ctrl_out    (ctrl_out),
        .load_ctrl   (load_ctrl),
        .start_ctrl  (start_ctrl),
        .stop_ctrl   (stop_ctrl),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a program is a timeline anchored at the cycle go was accepted;
    // abort just moves the start of the stop window earlier.
    logic [7:0] mm    [DEPTH];
    logic [7:0] words [DEPTH];
    int         t_go = -1, m_len = 0, stop_start = 0, cyc = 0;
    int         e_ph = P_IDLE;
    logic [7:0] e_ctrl = '0;
    logic       e_err = 1'b0;

    function automatic int phase_at(input int c);
        int d;
        if (t_go < 0) return P_IDLE;
        if (c >= stop_start) return (c < stop_start + STOPC) ? P_STOP : P_DONE;
        d = c - t_go;
        if (d <= m_len) return P_LOAD;
        if (d == m_len + 1) return P_GAP;
        return P_RUN;
    endfunction

    initial forever begin
        int   p;
        logic idle_like, ok;
        @(posedge clk2);
        p = phase_at(cyc);
        if (!rst2) begin
            t_go   = -1;
            e_ctrl = '0;
            e_err  = 1'b0;
            cyc++;
            e_ph   = P_IDLE;
        end else begin
            idle_like = (p == P_IDLE) || (p == P_DONE);
            ok        = (prog_len != 0) && (int'(prog_len) <= DEPTH);
            e_err     = (prog_wr_en && !idle_like) || (go && idle_like && !ok);
            if (prog_wr_en && idle_like) mm[prog_wr_addr] = prog_wr_data;
            if (go && idle_like && ok) begin
                t_go       = cyc;
                m_len      = int'(prog_len);
                words      = mm;
                stop_start = cyc + m_len + 2 + RUNC;
            end else if (abort && (p == P_LOAD || p == P_GAP || p == P_RUN)) begin
                stop_start = cyc + 1;
            end
            cyc++;
            e_ph = phase_at(cyc);
            if (e_ph == P_LOAD) e_ctrl = words[cyc - t_go - 1];
        end
    end

    initial forever begin
        @(negedge clk2);
        if (rst2) begin
            chk("m_ctrl_out",   32'(ctrl_out),   32'(e_ctrl));
            chk("m_load_ctrl",  32'(load_ctrl),  32'(e_ph == P_LOAD));
            chk("m_start_ctrl", 32'(start_ctrl), 32'(e_ph == P_RUN));
            chk("m_stop_ctrl",  32'(stop_ctrl),  32'(e_ph == P_STOP));
            chk("m_busy",       32'(busy),       32'(e_ph >= P_LOAD && e_ph <= P_STOP));
            chk("m_done",       32'(done),       32'(e_ph == P_DONE));
            chk("m_err",        32'(err),        32'(e_err));
        end
    end

    task automatic tick();
        @(negedge clk2);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        prog_wr_en = 1'b1; prog_wr_addr = a; prog_wr_data = d;
        tick();
        prog_wr_en = 1'b0;
    endtask

    task automatic start_go(input logic [4:0] len);
        go = 1'b1; prog_len = len;
        tick();
        go = 1'b0;
    endtask

    task automatic count_start(output int n);
        n = 0;
        while (start_ctrl && n < 3000) begin n++; tick(); end
    endtask

    task automatic count_stop(output int n);
        n = 0;
        while (stop_ctrl && n < 3000) begin n++; tick(); end
    endtask

    task automatic wait_start();
        int n = 0;
        while (!start_ctrl && n < 40) begin n++; tick(); end
        chk("start_reached", 32'(start_ctrl), 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 5000) begin n++; tick(); end
        chk("done_reached", 32'(done), 32'd1);
        chk("done_not_busy", 32'(busy), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"},  32'(ctrl_out),   32'd0);
        chk({tag, "_load"},  32'(load_ctrl),  32'd0);
        chk({tag, "_start"}, 32'(start_ctrl), 32'd0);
        chk({tag, "_stop"},  32'(stop_ctrl),  32'd0);
        chk({tag, "_busy"},  32'(busy),       32'd0);
        chk({tag, "_done"},  32'(done),       32'd0);
        chk({tag, "_err"},   32'(err),        32'd0);
    endtask

    initial begin
        int n;
        repeat (3) tick();
        chk_all_zero("reset");
        rst2 = 1'b1;
        tick();

        // Out-of-range lengths are rejected with a one-cycle err.
        start_go(5'd0);
        chk("len0_err", 32'(err), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        tick();
        chk("len0_err_clear", 32'(err), 32'd0);
        start_go(5'd17);
        chk("len17_err", 32'(err), 32'd1);
        chk("len17_load", 32'(load_ctrl), 32'd0);
        tick();
        chk("len17_err_clear", 32'(err), 32'd0);

        for (int i = 0; i < DEPTH; i++) wr(4'(i), 8'(8'h11 + i));

        // Basic 4-word program with full run and stop windows.
        start_go(5'd4);
        for (int k = 0; k < 4; k++) begin
            chk("p4_load", 32'(load_ctrl), 32'd1);
            chk("p4_word", 32'(ctrl_out), 32'(8'h11 + k));
            tick();
        end
        chk("gap_load", 32'(load_ctrl), 32'd0);
        chk("gap_start", 32'(start_ctrl), 32'd0);
        chk("gap_hold", 32'(ctrl_out), 32'h14);
        chk("gap_busy", 32'(busy), 32'd1);
        tick();
        count_start(n);
        chk("run_len", 32'(n), 32'd1000);
        count_stop(n);
        chk("stop_len", 32'(n), 32'd1000);
        wait_done();

        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done_ignored", 32'(done), 32'd1);
        chk("abort_done_nostop", 32'(stop_ctrl), 32'd0);

        // Abort on the 500th run cycle.
        start_go(5'd2);
        wait_start();
        repeat (499) tick();
        chk("run500_start", 32'(start_ctrl), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_run_start", 32'(start_ctrl), 32'd0);
        count_stop(n);
        chk("abort_run_stop_len", 32'(n), 32'd1000);
        wait_done();

        // Abort during the second LOAD word; writes and go while busy.
        start_go(5'd4);
        chk("ab_w0", 32'(ctrl_out), 32'h11);
        tick();
        chk("ab_w1", 32'(ctrl_out), 32'h12);
        chk("ab_w1_load", 32'(load_ctrl), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_load_low", 32'(load_ctrl), 32'd0);
        chk("ab_stop", 32'(stop_ctrl), 32'd1);
        chk("ab_hold", 32'(ctrl_out), 32'h12);
        wr(4'd1, 8'hEE);
        chk("busy_wr_err", 32'(err), 32'd1);
        start_go(5'd3);
        chk("busy_go_noerr", 32'(err), 32'd0);
        chk("busy_go_stop", 32'(stop_ctrl), 32'd1);
        wait_done();

        // Asynchronous reset in the middle of RUN.
        start_go(5'd3);
        wait_start();
        repeat (10) tick();
        #2 rst2 = 1'b0;
        #1 chk_all_zero("async_rst");
        tick();
        tick();
        rst2 = 1'b1;
        tick();

        // Full-depth program; entry 1 must still hold its pre-busy value.
        start_go(5'd16);
        for (int k = 0; k < DEPTH; k++) begin
            chk("p16_load", 32'(load_ctrl), 32'd1);
            chk("p16_word", 32'(ctrl_out), 32'(8'h11 + k));
            tick();
        end
        chk("p16_gap", 32'(load_ctrl), 32'd0);
        wait_done();

        // go, abort and a write to entry 0 in the same cycle: go wins, write is seen.
        prog_wr_en = 1'b1; prog_wr_addr = 4'd0; prog_wr_data = 8'h77;
        go = 1'b1; prog_len = 5'd1; abort = 1'b1;
        tick();
        prog_wr_en = 1'b0; go = 1'b0; abort = 1'b0;
        chk("gw_load", 32'(load_ctrl), 32'd1);
        chk("gw_word", 32'(ctrl_out), 32'h77);
        chk("gw_done_clr", 32'(done), 32'd0);
        tick();
        chk("gw_gap", 32'(load_ctrl), 32'd0);
        wait_done();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
